// File: rtl/shift_add_multiplier.sv
// Sequential 32x32->64 shift-add multiplier: one multiplier bit per clock, 32 iterations, one-cycle Ready strobe.
// Define MULT_SIGNED_EN for two's-complement operands (magnitude multiply with sign fix-up); default is unsigned.
//
//   state | meaning
//   IDLE  | waiting for Start; operands captured on the accepting edge
//   RUN   | one add-and-shift iteration per edge, counter 0..31
//   DONE  | Ready strobe; Product_out holds the new result
module shift_add_multiplier (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Multiplicand_in,
  input  logic [31:0] Multiplier_in,
  output logic [63:0] Product_out,
  output logic        Ready,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] p_q, p_d;
  logic [63:0] product_q, product_d;
  logic        ready_q, busy_q;
  logic [32:0] sum;
  logic [63:0] p_iter;
  logic [31:0] a_mag, b_mag;
  logic [63:0] p_final;

  // The carry bit of P lives only inside one iteration: it is always zero after the shift.
  assign sum    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign p_iter = {sum, p_q[31:1]};

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  assign a_mag   = Multiplicand_in[31] ? (~Multiplicand_in + 32'd1) : Multiplicand_in;
  assign b_mag   = Multiplier_in[31]   ? (~Multiplier_in + 32'd1)   : Multiplier_in;
  assign p_final = sign_q ? (~p_iter + 64'd1) : p_iter;

  always_comb begin
    sign_d = sign_q;
    if (state_q == IDLE && Start) sign_d = Multiplicand_in[31] ^ Multiplier_in[31];
  end

  always_ff @(posedge clk) begin
    if (Reset) sign_q <= 1'b0;
    else       sign_q <= sign_d;
  end
`else
  assign a_mag   = Multiplicand_in;
  assign b_mag   = Multiplier_in;
  assign p_final = p_iter;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          mcand_d = a_mag;
          p_d     = {32'd0, b_mag};
          cnt_d   = 5'd0;
        end
      end
      RUN: begin
        p_d   = p_iter;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d   = DONE;
          product_d = p_final;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      mcand_q   <= 32'd0;
      p_q       <= 64'd0;
      product_q <= 64'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      product_q <= product_d;
      ready_q   <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign Product_out = product_q;
  assign Ready       = ready_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier; expected products are queued at acceptance and compared at Ready.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Multiplicand_in = '0;
  logic [31:0] Multiplier_in = '0;
  logic [63:0] Product_out;
  logic        Ready;
  logic        Busy;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  shift_add_multiplier dut (
    .clk(clk), .Reset(Reset), .Start(Start),
    .Multiplicand_in(Multiplicand_in), .Multiplier_in(Multiplier_in),
    .Product_out(Product_out), .Ready(Ready), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [63:0] sa, sbv;
    sa  = $signed({{32{a[31]}}, a});
    sbv = $signed({{32{b[31]}}, b});
    return sa * sbv;
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  // Drive a request for the next edge (the accepting edge) and drop Start just after it.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    @(negedge clk);
    Start = 1'b1; Multiplicand_in = a; Multiplier_in = b;
    sb.push_back(exp);
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // Counts sampled cycles until Ready, bounded so a stuck DUT still reaches the summary.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!Ready && cyc < 80);
  endtask

  task automatic pop_expected(output logic [63:0] exp);
    if (sb.size() == 0) exp = 64'hDEAD_BEEF_DEAD_BEEF;
    else exp = sb.pop_front();
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    vectors++; if (Product_out !== 64'd0) begin miscompares++; $display("FAIL reset_product got %h want 0", Product_out); end
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", Ready); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", Busy); end
  endtask

  task automatic test_basic;
    int cyc;
    logic [63:0] exp;
    apply(32'd3, 32'd5, 64'h0F);
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", Busy); end
    wait_ready(cyc);
    pop_expected(exp);
    vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL basic_latency got %0d want 32", cyc); end
    vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL basic_product got %h want %h", Product_out, exp); end
    @(posedge clk); #1;
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_width got %b want 0", Ready); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b want 0", Busy); end
    repeat (3) @(posedge clk); #1;
    vectors++; if (Product_out !== 64'h0F) begin miscompares++; $display("FAIL basic_hold got %h want %h", Product_out, 64'h0F); end
  endtask

  task automatic test_corner;
    int cyc;
    logic [63:0] exp;
`ifdef MULT_SIGNED_EN
    logic [31:0] va[3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd0};
    logic [31:0] vb[3] = '{32'd5, 32'h8000_0000, 32'h1234_5678};
    logic [63:0] ve[3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000, 64'd0};
`else
    logic [31:0] va[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] vb[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [63:0] ve[3] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000, 64'd0};
`endif
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i], ve[i]);
      wait_ready(cyc);
      pop_expected(exp);
      vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL corner%0d_latency got %0d want 32", i, cyc); end
      vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL corner%0d_product got %h want %h", i, Product_out, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      apply(a, b, model(a, b));
      wait_ready(cyc);
      pop_expected(exp);
      vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL random%0d a=%h b=%h got %h want %h", i, a, b, Product_out, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    logic [63:0] exp;
    apply(32'h0000_1234, 32'h0000_5678, model(32'h0000_1234, 32'h0000_5678));
    repeat (5) @(posedge clk);
    #1;
    Start = 1'b1; Multiplicand_in = 32'h0BAD_0BAD; Multiplier_in = 32'h7777_0001;
    repeat (3) @(posedge clk);
    #1 Start = 1'b0;
    wait_ready(cyc);
    pop_expected(exp);
    vectors++; if (cyc + 8 !== 32) begin miscompares++; $display("FAIL ignored_latency got %0d want 32", cyc + 8); end
    vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL ignored_product got %h want %h", Product_out, exp); end
    @(posedge clk); #1;
    apply(32'd1000, 32'd2000, model(32'd1000, 32'd2000));
    wait_ready(cyc);
    pop_expected(exp);
    vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL after_ignored_product got %h want %h", Product_out, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int cyc, pulses;
    logic [63:0] exp;
    apply(32'h11, 32'h22, model(32'h11, 32'h22));
    repeat (10) @(posedge clk);
    #1;
    Reset = 1'b1; Start = 1'b1; Multiplicand_in = 32'd9; Multiplier_in = 32'd9;
    @(posedge clk); #1;
    Reset = 1'b0; Start = 1'b0;
    sb.delete();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", Busy); end
    vectors++; if (Product_out !== 64'd0) begin miscompares++; $display("FAIL abort_product got %h want 0", Product_out); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Ready) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abort_ready_pulses got %0d want 0", pulses); end
    apply(32'd7, 32'd6, 64'd42);
    wait_ready(cyc);
    pop_expected(exp);
    vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL fresh_latency got %0d want 32", cyc); end
    vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL fresh_product got %h want %h", Product_out, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    logic [63:0] exp;
    @(negedge clk);
    Start = 1'b1; Multiplicand_in = 32'h0001_0003; Multiplier_in = 32'h0002_0005;
    sb.push_back(model(32'h0001_0003, 32'h0002_0005));
    sb.push_back(model(32'h0001_0003, 32'h0002_0005));
    @(posedge clk); #1;
    wait_ready(c1);
    pop_expected(exp);
    vectors++; if (c1 !== 32) begin miscompares++; $display("FAIL b2b_first_latency got %0d want 32", c1); end
    vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL b2b_first_product got %h want %h", Product_out, exp); end
    wait_ready(c2);
    Start = 1'b0;
    pop_expected(exp);
    vectors++; if (c2 !== 34) begin miscompares++; $display("FAIL b2b_period got %0d want 34", c2); end
    vectors++; if (Product_out !== exp) begin miscompares++; $display("FAIL b2b_second_product got %h want %h", Product_out, exp); end
    repeat (3) @(posedge clk); #1;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_busy got %b want 0", Busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential 32×32→64 shift-add multiplier, the companion to the restoring divider in the arithmetic unit. It captures two operands on a start request and runs one multiplier bit per clock for 32 iterations. It then presents the 64-bit product with a one-cycle ready strobe. It uses the same load-then-run register discipline as the divider datapath, so the controller can issue multiply and divide through the same start/ready handshake.

## Interface
Parameters:
- none; operand width is fixed at 32 and product width at 64.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- Reset, input, 1: synchronous, active-high; clears all state on the rising edge of clk.
- Start, input, 1: operation request; sampled only in IDLE.
- Multiplicand_in, input, 32: operand A; captured on the accepting edge.
- Multiplier_in, input, 32: operand B; captured on the accepting edge.
- Product_out, output, 64: result register; holds the last completed product.
- Ready, output, 1: one-cycle strobe; Product_out is valid and new.
- Busy, output, 1: high in RUN and DONE; Start is ignored while high.

## Operation
- States:
  - IDLE: waits for Start.
  - RUN: iterates; a 5-bit counter counts 0..31.
  - DONE: presents the result.
- IDLE→RUN on an edge with Start=1.
  - That edge captures the multiplicand into a 32-bit register (Mcand).
  - Internal product register P (65 bits: carry, upper 32, lower 32) ← {1'b0, 32'b0, multiplier}.
  - Counter ← 0.
- Each RUN edge performs one iteration:
  - If P[0]=1, P[64:32] ← P[63:32] + Mcand as a 33-bit add.
  - Then P ← P >> 1 (logical; the carry shifts into bit 63).
  - Counter increments.
- RUN→DONE on the edge that completes iteration 31 (counter==31).
  - The same edge loads Product_out ← P[63:0], after sign fix-up when configured.
- DONE→IDLE unconditionally on the next edge.
- Start is ignored in RUN and DONE.
  - It is not queued; the caller must re-assert it in IDLE.
- Operands need only be stable on the accepting edge; later changes have no effect.
- Product_out changes only on the RUN→DONE edge or on Reset. It holds between operations.
- Reset has priority over everything:
  - Reset mid-operation aborts to IDLE and clears Product_out.
  - Reset and Start on the same edge → IDLE; the request is dropped.
- Zero operands follow the full 32-iteration path; there is no early termination.

## Timing
- Reset values: Product_out=64'h0, Ready=0, Busy=0; state IDLE, counter 0.
- Accepting edge E0: Busy=1 from the cycle after E0.
- Iterations run on edges E1..E32.
  - E32 enters DONE.
  - Ready=1 and Product_out is valid for the single cycle after E32.
- E33 returns to IDLE: Busy=0, Ready=0.
  - Start high in the cycle after E33 is accepted on E34.
- Latency from accepting edge to Ready: 32 cycles.
- Throughput: one product per 34 cycles with Start held high continuously.
- Ready and Busy are registered outputs; no combinational path from inputs to outputs.

## Configuration
- MULT_SIGNED_EN defined: operands are two's complement.
  - On acceptance, Mcand ← |A| and the multiplier ← |B|, each held as 32-bit unsigned.
  - 0x80000000 maps to magnitude 0x80000000.
  - The sign flag is A[31]^B[31].
  - On the RUN→DONE edge, Product_out ← sign ? −P[63:0] : P[63:0] (64-bit two's complement).
  - Latency is unchanged.
- MULT_SIGNED_EN undefined: operands are unsigned.
  - No sign logic; Product_out ← P[63:0].

## Test plan
- Reset 2 cycles, then check outputs → Product_out=0, Ready=0, Busy=0.
- Start with A=3, B=5 → Ready exactly 32 cycles after the accepting edge; Product_out=64'h0F; Ready high one cycle; value held afterwards.
- Unsigned build: A=B=0xFFFFFFFF → 64'hFFFFFFFE00000001.
- Signed build:
  - A=0xFFFFFFFD (−3), B=5 → 64'hFFFFFFFFFFFFFFF1.
  - A=B=0x80000000 → 64'h4000000000000000.
- Start asserted mid-RUN with different operands → ignored; the original product is delivered. A subsequent Start in IDLE is accepted.
- Reset asserted at iteration 10 together with Start → IDLE next cycle, Product_out=0, no Ready pulse; a fresh 7×6 then yields 42 with normal latency.
